// File: rtl/imm_pkg.sv
// Shared opcodes, format encodings and payload tag for the immediate generator.
package imm_pkg;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_SHAMT   = 3'd6,
    FMT_ILLEGAL = 3'd7
  } fmt_e;

  // Width-independent part of a decoded word; the XLEN-wide immediate is
  // joined to it inside the pipe, where XLEN is known.
  typedef struct packed {
    fmt_e fmt;
    logic illegal;
  } tag_t;

  function automatic logic is_shift_imm(input logic [2:0] funct3);
    return (funct3 == F3_SLLI) || (funct3 == F3_SRLI_SRAI);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle for imm_gen_pipe.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             valid_i;
  logic             ready_o;
  logic [31:0]      instruction_i;
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  immediate_o;
  logic [2:0]       format_o;
  logic             illegal_o;
  logic [CNT_W-1:0] illegal_count_o;

  // Block side
  modport slave (
    input  valid_i, instruction_i, ready_i,
    output ready_o, valid_o, immediate_o, format_o, illegal_o, illegal_count_o
  );

  // Producer/consumer side
  modport master (
    output valid_i, instruction_i, ready_i,
    input  ready_o, valid_o, immediate_o, format_o, illegal_o, illegal_count_o
  );
endinterface

// File: rtl/imm_decode.sv
// Combinational opcode classification and immediate assembly.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] immediate,
  output tag_t            tag
);

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic signed [11:0] imm_i;
  logic signed [11:0] imm_s;
  logic signed [12:0] imm_b;
  logic signed [20:0] imm_j;
  logic signed [31:0] imm_u;
  logic [5:0]         shamt;
  fmt_e               fmt;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];

  assign imm_i = instruction[31:20];
  assign imm_s = {instruction[31:25], instruction[11:7]};
  assign imm_b = {instruction[31], instruction[7], instruction[30:25],
                  instruction[11:8], 1'b0};
  assign imm_j = {instruction[31], instruction[19:12], instruction[20],
                  instruction[30:21], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};

  // RV64 shifts use a 6-bit amount; on RV32 bit 25 belongs to funct7.
  assign shamt = (XLEN == 64) ? instruction[25:20] : {1'b0, instruction[24:20]};

  // Pick format and build the extended immediate; signed casts do the sign extension.
  always_comb begin
    fmt       = FMT_ILLEGAL;
    immediate = '0;
    case (opcode)
      OP_IMM: begin
        if (is_shift_imm(funct3)) begin
          fmt       = FMT_SHAMT;
          immediate = XLEN'(shamt);
        end else begin
          fmt       = FMT_I;
          immediate = XLEN'(imm_i);
        end
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt       = FMT_I;
        immediate = XLEN'(imm_i);
      end
      OP_STORE: begin
        fmt       = FMT_S;
        immediate = XLEN'(imm_s);
      end
      OP_BRANCH: begin
        fmt       = FMT_B;
        immediate = XLEN'(imm_b);
      end
      OP_LUI, OP_AUIPC: begin
        fmt       = FMT_U;
        immediate = XLEN'(imm_u);
      end
      OP_JAL: begin
        fmt       = FMT_J;
        immediate = XLEN'(imm_j);
      end
      OP_REG: begin
        fmt       = FMT_R;
        immediate = '0;
      end
      default: begin
        fmt       = FMT_ILLEGAL;
        immediate = '0;
      end
    endcase
  end

  assign tag.fmt     = fmt;
  assign tag.illegal = (fmt == FMT_ILLEGAL);

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode, OUT/SKID buffer, illegal-opcode counter.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    tag_t            tag;
  } word_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             accept;
  logic             drain;
  logic             out_load;
  logic             out_valid;
  logic             skid_valid;
  word_t            dec_word;
  word_t            out_q;
  word_t            skid_q;
  logic [CNT_W-1:0] illegal_count;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instruction (bus.instruction_i),
    .immediate   (dec_word.imm),
    .tag         (dec_word.tag)
  );

  // ready_o comes only from registered SKID state, so ready_i never reaches it.
  assign accept   = bus.valid_i && !skid_valid;
  assign drain    = out_valid && bus.ready_i;
  assign out_load = drain || !out_valid;

  // Occupancy: OUT refills from SKID first so order is kept, else from the new word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_load) begin
      out_valid  <= skid_valid || accept;
      skid_valid <= skid_valid && accept;
    end else begin
      skid_valid <= skid_valid || accept;
    end
  end

  // Payload registers only move when their slot is loaded, so a stalled OUT stays stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else if (out_load) begin
      if (skid_valid) begin
        out_q <= skid_q;
      end else if (accept) begin
        out_q <= dec_word;
      end
      if (skid_valid && accept) begin
        skid_q <= dec_word;
      end
    end else if (accept) begin
      skid_q <= dec_word;
    end
  end

  // Count accepted illegal words, sticking at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_count <= '0;
    end else if (accept && dec_word.tag.illegal && (illegal_count != CNT_MAX)) begin
      illegal_count <= illegal_count + 1'b1;
    end
  end

  assign bus.ready_o         = !skid_valid;
  assign bus.valid_o         = out_valid;
  assign bus.immediate_o     = out_q.imm;
  assign bus.format_o        = out_q.tag.fmt;
  assign bus.illegal_o       = out_q.tag.illegal;
  assign bus.illegal_count_o = illegal_count;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: one XLEN=32/CNT_W=16 instance and one XLEN=64/CNT_W=2 instance.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .CNT_W(16)) a ();
  imm_gen_pipe_if #(.XLEN(64), .CNT_W(2))  b ();

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(a));
  imm_gen_pipe #(.XLEN(64), .CNT_W(2))  dut_b (.clk(clk), .reset(reset), .bus(b));

  localparam int NV = 13;
  logic [31:0] v_inst [NV] = '{
    32'hFFF00093, 32'h7FF00093, 32'h123450B7, 32'h80000017, 32'hFE20AE23,
    32'h001000EF, 32'hFE000EE3, 32'h00509093, 32'h40515093, 32'h03F09093,
    32'h002081B3, 32'h80008067, 32'h30200073};
  logic [31:0] v_imm [NV] = '{
    32'hFFFFFFFF, 32'h000007FF, 32'h12345000, 32'h80000000, 32'hFFFFFFFC,
    32'h00000800, 32'hFFFFFFFC, 32'h00000005, 32'h00000005, 32'h0000001F,
    32'h00000000, 32'hFFFFF800, 32'h00000302};
  logic [2:0] v_fmt [NV] = '{
    3'd1, 3'd1, 3'd4, 3'd4, 3'd2, 3'd5, 3'd3, 3'd6, 3'd6, 3'd6, 3'd0, 3'd1, 3'd1};

  localparam int NW = 3;
  logic [31:0] w_inst [NW] = '{32'h800000B7, 32'h03F09093, 32'hFFF00093};
  logic [63:0] w_imm  [NW] = '{64'hFFFFFFFF80000000, 64'h000000000000003F,
                               64'hFFFFFFFFFFFFFFFF};
  logic [2:0]  w_fmt  [NW] = '{3'd4, 3'd6, 3'd1};

  logic [31:0] btb_words [4] = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};
  logic [31:0] btb_got [$];

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++; if (a.valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", a.valid_o); end
    total++; if (a.ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", a.ready_o); end
    total++; if (a.immediate_o !== 32'h0) begin bad++; $display("FAIL rst_imm got=%h exp=0", a.immediate_o); end
    total++; if (a.format_o !== 3'd0) begin bad++; $display("FAIL rst_fmt got=%0d exp=0", a.format_o); end
    total++; if (a.illegal_o !== 1'b0) begin bad++; $display("FAIL rst_illegal got=%b exp=0", a.illegal_o); end
    total++; if (a.illegal_count_o !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", a.illegal_count_o); end
    total++; if (b.valid_o !== 1'b0 || b.ready_o !== 1'b1) begin bad++; $display("FAIL rst_b got=%b%b exp=01", b.valid_o, b.ready_o); end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_formats();
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      a.valid_i = 1'b1; a.instruction_i = v_inst[k]; a.ready_i = 1'b1;
      #1;
      total++; if (a.valid_o !== 1'b0) begin bad++; $display("FAIL fmt_pre_valid[%0d] got=%b exp=0", k, a.valid_o); end
      @(negedge clk);
      a.valid_i = 1'b0;
      total++; if (a.valid_o !== 1'b1) begin bad++; $display("FAIL fmt_valid[%0d] got=%b exp=1", k, a.valid_o); end
      total++; if (a.immediate_o !== v_imm[k]) begin bad++; $display("FAIL fmt_imm[%0d] got=%h exp=%h", k, a.immediate_o, v_imm[k]); end
      total++; if (a.format_o !== v_fmt[k]) begin bad++; $display("FAIL fmt_fmt[%0d] got=%0d exp=%0d", k, a.format_o, v_fmt[k]); end
      total++; if (a.illegal_o !== 1'b0) begin bad++; $display("FAIL fmt_illegal[%0d] got=%b exp=0", k, a.illegal_o); end
    end
    @(negedge clk);
    total++; if (a.valid_o !== 1'b0) begin bad++; $display("FAIL fmt_drained got=%b exp=0", a.valid_o); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    a.valid_i = 1'b1; a.instruction_i = 32'h0000007F; a.ready_i = 1'b1;
    #1;
    total++; if (a.illegal_count_o !== 16'd0) begin bad++; $display("FAIL ill_count_before got=%0d exp=0", a.illegal_count_o); end
    @(negedge clk);
    a.valid_i = 1'b0;
    total++; if (a.valid_o !== 1'b1) begin bad++; $display("FAIL ill_valid got=%b exp=1", a.valid_o); end
    total++; if (a.immediate_o !== 32'h0) begin bad++; $display("FAIL ill_imm got=%h exp=0", a.immediate_o); end
    total++; if (a.format_o !== 3'd7) begin bad++; $display("FAIL ill_fmt got=%0d exp=7", a.format_o); end
    total++; if (a.illegal_o !== 1'b1) begin bad++; $display("FAIL ill_flag got=%b exp=1", a.illegal_o); end
    total++; if (a.illegal_count_o !== 16'd1) begin bad++; $display("FAIL ill_count_after got=%0d exp=1", a.illegal_count_o); end
  endtask

  task automatic test_xlen64();
    for (int k = 0; k < NW; k++) begin
      @(negedge clk);
      b.valid_i = 1'b1; b.instruction_i = w_inst[k]; b.ready_i = 1'b1;
      @(negedge clk);
      b.valid_i = 1'b0;
      total++; if (b.valid_o !== 1'b1) begin bad++; $display("FAIL x64_valid[%0d] got=%b exp=1", k, b.valid_o); end
      total++; if (b.immediate_o !== w_imm[k]) begin bad++; $display("FAIL x64_imm[%0d] got=%h exp=%h", k, b.immediate_o, w_imm[k]); end
      total++; if (b.format_o !== w_fmt[k]) begin bad++; $display("FAIL x64_fmt[%0d] got=%0d exp=%0d", k, b.format_o, w_fmt[k]); end
    end
  endtask

  task automatic test_saturate();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      b.valid_i = 1'b1; b.instruction_i = 32'h0000007F; b.ready_i = 1'b1;
      @(negedge clk);
      b.valid_i = 1'b0;
      total++;
      if (b.illegal_count_o !== ((k < 3) ? 2'(k) : 2'd3)) begin
        bad++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", k, b.illegal_count_o, (k < 3) ? k : 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int cyc = 0;
    btb_got.delete();
    while (btb_got.size() < 4 && cyc < 40) begin
      @(negedge clk);
      a.valid_i = (idx < 4);
      a.instruction_i = (idx < 4) ? btb_words[idx] : 32'h0;
      a.ready_i = (cyc >= 3);
      #1;
      if (cyc == 2) begin
        total++; if (a.ready_o !== 1'b0) begin bad++; $display("FAIL btb_ready_drop got=%b exp=0", a.ready_o); end
        total++; if (idx != 2) begin bad++; $display("FAIL btb_accepts got=%0d exp=2", idx); end
        total++; if (a.valid_o !== 1'b1 || a.immediate_o !== 32'h1) begin
          bad++; $display("FAIL btb_stall_out got=%b/%h exp=1/00000001", a.valid_o, a.immediate_o);
        end
      end
      if (a.valid_o && a.ready_i) btb_got.push_back(a.immediate_o);
      if (a.valid_i && a.ready_o) idx++;
      cyc++;
    end
    a.valid_i = 1'b0;
    total++; if (btb_got.size() != 4) begin bad++; $display("FAIL btb_timeout got=%0d exp=4", btb_got.size()); end
    for (int k = 0; k < btb_got.size(); k++) begin
      total++; if (btb_got[k] !== 32'(k + 1)) begin bad++; $display("FAIL btb_order[%0d] got=%h exp=%h", k, btb_got[k], k + 1); end
    end
    @(negedge clk);
    total++; if (a.valid_o !== 1'b0) begin bad++; $display("FAIL btb_no_dup got=%b exp=0", a.valid_o); end
  endtask

  task automatic test_reset_full();
    @(negedge clk);
    a.ready_i = 1'b0; a.valid_i = 1'b1; a.instruction_i = 32'h0000007F;
    @(negedge clk);
    a.instruction_i = 32'h00100093;
    @(negedge clk);
    a.valid_i = 1'b0;
    total++; if (a.ready_o !== 1'b0 || a.valid_o !== 1'b1) begin bad++; $display("FAIL rf_full got=%b%b exp=01", a.ready_o, a.valid_o); end
    total++; if (a.illegal_o !== 1'b1) begin bad++; $display("FAIL rf_head got=%b exp=1", a.illegal_o); end
    total++; if (a.illegal_count_o !== 16'd2) begin bad++; $display("FAIL rf_count_before got=%0d exp=2", a.illegal_count_o); end
    #2 reset = 1'b1;
    #1;
    total++; if (a.valid_o !== 1'b0) begin bad++; $display("FAIL rf_valid got=%b exp=0", a.valid_o); end
    total++; if (a.ready_o !== 1'b1) begin bad++; $display("FAIL rf_ready got=%b exp=1", a.ready_o); end
    total++; if (a.illegal_count_o !== 16'd0) begin bad++; $display("FAIL rf_count got=%0d exp=0", a.illegal_count_o); end
    total++; if (a.immediate_o !== 32'h0 || a.format_o !== 3'd0) begin bad++; $display("FAIL rf_data got=%h/%0d exp=0/0", a.immediate_o, a.format_o); end
    total++; if (b.illegal_count_o !== 2'd0) begin bad++; $display("FAIL rf_count_b got=%0d exp=0", b.illegal_count_o); end
    @(negedge clk);
    reset = 1'b0; a.ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (a.valid_o !== 1'b0) begin bad++; $display("FAIL rf_ghost[%0d] got=%b exp=0", k, a.valid_o); end
    end
  endtask

  initial begin
    a.valid_i = 1'b0; a.instruction_i = 32'h0; a.ready_i = 1'b1;
    b.valid_i = 1'b0; b.instruction_i = 32'h0; b.ready_i = 1'b1;
    test_reset();
    test_formats();
    test_illegal();
    test_xlen64();
    test_saturate();
    test_back_to_back();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
